axis_elastic_fifo: RTL and testbench

Parametrised elastic AXI-Stream buffer for the Dct2 datapath. It generalises the two-entry pipelined register slice to a configurable capacity, with:
- registered s_ready_o and m_valid_o, so there is no combinational path between the two sides;
- an occupancy output and an almost-full flag;
- a synchronous flush.

It sits between DCT stages where burst decoupling deeper than two beats is needed.

---
 rtl/axis_pkg.sv | 19 +
 rtl/axis_fifo_mem.sv | 24 ++
 rtl/axis_elastic_fifo.sv | 131 +++++++++++++
 tb/tb_axis_elastic_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared sizing helpers for the elastic AXI-Stream FIFO.
package axis_pkg;

   // Bits needed to hold an occupancy count of 0..depth.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address the depth-1 entry buffer (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth - 1 > 1) ? $clog2(depth - 1) : 1;
   endfunction

   // Circular increment over 0..depth-2; depth-1 need not be a power of two.
   function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 2) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Register array backing the FIFO: one write port, one asynchronous read port.
module axis_fifo_mem #(
   parameter int unsigned Width   = 17,
   parameter int unsigned Entries = 3,
   parameter int unsigned PtrW    = 2
) (
   input  logic             clk_i,
   input  logic             wr_en,
   input  logic [PtrW-1:0]  wr_ptr,
   input  logic [Width-1:0] wr_data,
   input  logic [PtrW-1:0]  rd_ptr,
   output logic [Width-1:0] rd_data
);

   logic [Width-1:0] mem_q [Entries];

   // Storage write; contents are never reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/axis_elastic_fifo.sv
// Elastic AXI-Stream buffer: registered output beat plus a Depth-1 entry buffer,
// registered ready/valid/level/almost-full and a synchronous flush.
module axis_elastic_fifo
   import axis_pkg::*;
#(
   parameter int unsigned DataWidth       = 16,
   parameter int unsigned SideDataWidth   = 1,
   parameter int unsigned Depth           = 4,
   parameter int unsigned AlmostFullLevel = 3
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   output logic                          s_ready_o,
   input  logic                          s_valid_i,
   input  logic [DataWidth-1:0]          s_data_i,
   input  logic [SideDataWidth-1:0]      s_side_data_i,
   input  logic                          m_ready_i,
   output logic                          m_valid_o,
   output logic [DataWidth-1:0]          m_data_o,
   output logic [SideDataWidth-1:0]      m_side_data_o,
   output logic [level_width(Depth)-1:0] level_o,
   output logic                          almost_full_o
);

   localparam int unsigned LevelW     = level_width(Depth);
   localparam int unsigned PtrW       = ptr_width(Depth);
   localparam int unsigned EntryW     = DataWidth + SideDataWidth;
   localparam int unsigned NumEntries = Depth - 1;

   typedef logic [LevelW-1:0] level_t;
   typedef logic [PtrW-1:0]   ptr_t;
   typedef logic [EntryW-1:0] entry_t;

   level_t level_q, level_d;
   ptr_t   rd_ptr_q, rd_ptr_d;
   ptr_t   wr_ptr_q, wr_ptr_d;
   logic   valid_q, valid_d;
   logic   ready_q, ready_d;
   logic   af_q, af_d;
   entry_t out_q, out_d;

   logic   accept, emit, out_free, buf_nonempty;
   logic   load_buf, load_in, mem_wr;
   level_t buf_count, level_next;
   entry_t rd_data;

   axis_fifo_mem #(
      .Width   (EntryW),
      .Entries (NumEntries),
      .PtrW    (PtrW)
   ) u_mem (
      .clk_i   (clk_i),
      .wr_en   (mem_wr),
      .wr_ptr  (wr_ptr_q),
      .wr_data ({s_side_data_i, s_data_i}),
      .rd_ptr  (rd_ptr_q),
      .rd_data (rd_data)
   );

   // Handshakes, output-register load selection, buffer pointers and flags.
   // The buffer holds level-valid beats; the output register is refilled from
   // the buffer head first so ordering holds, and from the input only when the
   // buffer is empty.
   always_comb begin
      accept       = s_valid_i & ready_q;
      emit         = valid_q & m_ready_i;
      out_free     = ~valid_q | emit;
      buf_count    = level_q - level_t'(valid_q);
      buf_nonempty = (buf_count != '0);
      load_buf     = out_free & buf_nonempty;
      load_in      = out_free & ~buf_nonempty & accept;
      level_next   = level_q + level_t'(accept) - level_t'(emit);

      mem_wr   = accept & ~load_in & ~flush_i;
      level_d  = level_next;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      valid_d  = (level_next != '0);
      ready_d  = (level_next < level_t'(Depth));
      af_d     = (level_next >= level_t'(AlmostFullLevel));
      out_d    = out_q;

      if (load_buf)      out_d = rd_data;
      else if (load_in)  out_d = {s_side_data_i, s_data_i};

      if (load_buf)      rd_ptr_d = ptr_t'(ptr_wrap(32'(rd_ptr_q), Depth));
      if (mem_wr)        wr_ptr_d = ptr_t'(ptr_wrap(32'(wr_ptr_q), Depth));

      if (flush_i) begin
         level_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         valid_d  = 1'b0;
         ready_d  = 1'b1;
         af_d     = 1'b0;
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b0;
         af_q     <= 1'b0;
      end else begin
         level_q  <= level_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
         af_q     <= af_d;
      end
   end

   // Output data register, not reset.
   always_ff @(posedge clk_i) begin
      out_q <= out_d;
   end

   assign s_ready_o     = ready_q;
   assign m_valid_o     = valid_q;
   assign m_data_o      = out_q[DataWidth-1:0];
   assign m_side_data_o = out_q[EntryW-1 -: SideDataWidth];
   assign level_o       = level_q;
   assign almost_full_o = af_q;

endmodule

// File: tb/tb_axis_elastic_fifo.sv
// Bench for axis_elastic_fifo: directed vector table on a Depth=4 instance,
// hand sequences for asynchronous reset, and a randomized scoreboard on Depth=5.
module tb_axis_elastic_fifo;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Depth=4 instance
   logic        flush4, v4, r4, s4;
   logic [15:0] d4;
   logic        sr4, mv4, ms4, af4;
   logic [15:0] md4;
   logic [2:0]  lvl4;

   // Depth=5 instance
   logic        flush5, v5, r5, s5;
   logic [15:0] d5;
   logic        sr5, mv5, ms5, af5;
   logic [15:0] md5;
   logic [2:0]  lvl5;

   axis_elastic_fifo #(.DataWidth(16), .SideDataWidth(1), .Depth(4), .AlmostFullLevel(3)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush4),
      .s_ready_o(sr4), .s_valid_i(v4), .s_data_i(d4), .s_side_data_i(s4),
      .m_ready_i(r4), .m_valid_o(mv4), .m_data_o(md4), .m_side_data_o(ms4),
      .level_o(lvl4), .almost_full_o(af4));

   axis_elastic_fifo #(.DataWidth(16), .SideDataWidth(1), .Depth(5), .AlmostFullLevel(3)) dut5 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush5),
      .s_ready_o(sr5), .s_valid_i(v5), .s_data_i(d5), .s_side_data_i(s5),
      .m_ready_i(r5), .m_valid_o(mv5), .m_data_o(md5), .m_side_data_o(ms5),
      .level_o(lvl5), .almost_full_o(af5));

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        s;
      logic        r;
      logic        f;
      logic        e_sr;
      logic        e_mv;
      logic [15:0] e_d;
      logic        e_s;
      logic [2:0]  e_lvl;
      logic        e_af;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [15:0] d, input logic s, input logic r,
                               input logic f, input logic e_sr, input logic e_mv,
                               input logic [15:0] e_d, input logic e_s, input logic [2:0] e_lvl,
                               input logic e_af);
      vec_t t;
      t.v = v; t.d = d; t.s = s; t.r = r; t.f = f;
      t.e_sr = e_sr; t.e_mv = e_mv; t.e_d = e_d; t.e_s = e_s; t.e_lvl = e_lvl; t.e_af = e_af;
      return t;
   endfunction

   vec_t vecs[19];

   initial begin
      int unsigned q[$];
      int unsigned sent, rcvd, mlevel, cyc;
      logic acc, emt;
      string nm;

      // inputs idle, reset asserted
      flush4 = 0; v4 = 0; r4 = 0; s4 = 0; d4 = '0;
      flush5 = 0; v5 = 0; r5 = 0; s5 = 0; d5 = '0;

      //          v  d        s  r  f   sr mv e_d     es lvl af
      vecs[0]  = mk(0, 16'h0000, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0);
      vecs[1]  = mk(1, 16'h1234, 1, 1, 0,  1, 1, 16'h1234, 1, 1, 0);
      vecs[2]  = mk(0, 16'h0000, 0, 1, 0,  1, 0, 16'h0000, 0, 0, 0);
      vecs[3]  = mk(1, 16'h0001, 1, 0, 0,  1, 1, 16'h0001, 1, 1, 0);
      vecs[4]  = mk(1, 16'h0002, 0, 0, 0,  1, 1, 16'h0001, 1, 2, 0);
      vecs[5]  = mk(1, 16'h0003, 1, 0, 0,  1, 1, 16'h0001, 1, 3, 1);
      vecs[6]  = mk(1, 16'h0004, 0, 0, 0,  0, 1, 16'h0001, 1, 4, 1);
      vecs[7]  = mk(1, 16'h0005, 1, 0, 0,  0, 1, 16'h0001, 1, 4, 1);
      vecs[8]  = mk(1, 16'h0005, 1, 1, 0,  1, 1, 16'h0002, 0, 3, 1);
      vecs[9]  = mk(1, 16'h0005, 1, 1, 0,  1, 1, 16'h0003, 1, 3, 1);
      vecs[10] = mk(0, 16'h0000, 0, 1, 0,  1, 1, 16'h0004, 0, 2, 0);
      vecs[11] = mk(0, 16'h0000, 0, 1, 0,  1, 1, 16'h0005, 1, 1, 0);
      vecs[12] = mk(0, 16'h0000, 0, 1, 0,  1, 0, 16'h0000, 0, 0, 0);
      vecs[13] = mk(1, 16'h00A1, 0, 0, 0,  1, 1, 16'h00A1, 0, 1, 0);
      vecs[14] = mk(1, 16'h00A2, 0, 0, 0,  1, 1, 16'h00A1, 0, 2, 0);
      vecs[15] = mk(1, 16'h00A3, 0, 0, 0,  1, 1, 16'h00A1, 0, 3, 1);
      vecs[16] = mk(1, 16'h00A4, 0, 0, 1,  1, 0, 16'h0000, 0, 0, 0);
      vecs[17] = mk(1, 16'hBEEF, 1, 0, 0,  1, 1, 16'hBEEF, 1, 1, 0);
      vecs[18] = mk(0, 16'h0000, 0, 1, 0,  1, 0, 16'h0000, 0, 0, 0);

      // reset values while held
      #13;
      chk("rst_s_ready", 32'(sr4), 0);
      chk("rst_m_valid", 32'(mv4), 0);
      chk("rst_level",   32'(lvl4), 0);
      chk("rst_af",      32'(af4), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed table on Depth=4
      for (int i = 0; i < 19; i++) begin
         v4 = vecs[i].v; d4 = vecs[i].d; s4 = vecs[i].s; r4 = vecs[i].r; flush4 = vecs[i].f;
         @(posedge clk); #1;
         nm = $sformatf("vec%0d", i);
         chk({nm, "_s_ready"}, 32'(sr4), 32'(vecs[i].e_sr));
         chk({nm, "_m_valid"}, 32'(mv4), 32'(vecs[i].e_mv));
         chk({nm, "_level"},   32'(lvl4), 32'(vecs[i].e_lvl));
         chk({nm, "_af"},      32'(af4), 32'(vecs[i].e_af));
         if (vecs[i].e_mv) begin
            chk({nm, "_data"}, 32'(md4), 32'(vecs[i].e_d));
            chk({nm, "_side"}, 32'(ms4), 32'(vecs[i].e_s));
         end
      end
      v4 = 0; r4 = 0; flush4 = 0;

      // asynchronous reset mid-burst at level 2
      v4 = 1; d4 = 16'h0C01; s4 = 0;
      @(posedge clk); #1;
      d4 = 16'h0C02;
      @(posedge clk); #1;
      v4 = 0;
      chk("pre_rst_level", 32'(lvl4), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_s_ready", 32'(sr4), 0);
      chk("async_rst_m_valid", 32'(mv4), 0);
      chk("async_rst_level",   32'(lvl4), 0);
      chk("async_rst_af",      32'(af4), 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_s_ready", 32'(sr4), 1);
      chk("post_rst_m_valid", 32'(mv4), 0);
      chk("post_rst_level",   32'(lvl4), 0);
      v4 = 1; d4 = 16'h0D0D; s4 = 1; r4 = 0;
      @(posedge clk); #1;
      v4 = 0;
      chk("post_rst_first_data", 32'(md4), 32'h0D0D);
      chk("post_rst_level1",     32'(lvl4), 1);

      // randomized traffic on Depth=5 against a queue model
      sent = 0; rcvd = 0; mlevel = 0; cyc = 0;
      while (rcvd < 1000 && cyc < 20000) begin
         v5 = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         d5 = 16'(sent);
         s5 = d5[0];
         r5 = 1'($urandom_range(0, 1));
         #1;
         acc = v5 & (mlevel < 5);
         emt = r5 & (mlevel != 0);
         if (emt) begin
            if (md5 !== 16'(q[0]) || ms5 !== q[0][0]) begin
               n_total++;
               $display("FAIL rand_data cycle=%0d actual=%0h/%0h required=%0h/%0h",
                        cyc, md5, ms5, 16'(q[0]), q[0][0]);
            end
            void'(q.pop_front());
            rcvd++;
         end
         if (acc) begin
            q.push_back(sent);
            sent++;
         end
         mlevel = mlevel + 32'(acc) - 32'(emt);
         @(posedge clk); #1;
         cyc++;
         n_total++;
         if (32'(lvl5) == mlevel && sr5 === (mlevel < 5) && mv5 === (mlevel != 0)
             && af5 === (mlevel >= 3) && mlevel <= 5)
            n_pass++;
         else
            $display("FAIL rand_state cycle=%0d actual lvl=%0d sr=%0b mv=%0b af=%0b required lvl=%0d",
                     cyc, lvl5, sr5, mv5, af5, mlevel);
      end
      v5 = 0; r5 = 0;
      chk("rand_timeout_rcvd", rcvd, 1000);
      chk("rand_sent", sent, 1000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
